// File: rtl/pe_disp_pkg.sv
// pe_disp_pkg
//   Shared constants for the priority-encoder display slice: the blank
//   segment pattern, the gfedcba codes for decimal digits 0..9, and a
//   helper that maps a BCD nibble to its segment code.
package pe_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    // Nibble values above 9 have no decimal glyph and show as all-off.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder
//   Combinational BCD to 7-segment decoder with a blanking override.
//   Ports:
//     bcd    in   4   BCD digit value
//     blank  in   1   1: force all segments off
//     seg    out  7   gfedcba, active-high
module seg7_decoder
    import pe_disp_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            seg = bcd_to_seg(bcd);
        end
    end

endmodule

// File: rtl/priority_encoder_scan_display.sv
// priority_encoder_scan_display
//   Synchronises a raw request vector, priority-encodes it (MSB-first or
//   LSB-first), registers the index with an optional hold, and shows the
//   index in decimal on a time-multiplexed 7-segment display.
//   Ports:
//     clk        in   1       clock
//     rst_n      in   1       asynchronous active-low reset
//     data       in   WIDTH   raw request bits, asynchronous to clk
//     lsb_first  in   1       0: bit WIDTH-1 wins; 1: bit 0 wins
//     hold       in   1       1: freeze index/valid, scanning continues
//     segments   out  7       gfedcba of the enabled digit, active-high
//     dp         out  1       decimal point, lit on units digit when no data
//     digit_en   out  DIGITS  one-hot digit select, bit0 = units
//     index      out  IDX_W   registered encoded index
//     valid      out  1       registered: some synced data bit is set
//   Every output comes straight from a flop; no input reaches an output
//   combinationally.
module priority_encoder_scan_display
    import pe_disp_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int DIGITS   = 2,
    parameter  int SCAN_DIV = 1024,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  data,
    input  logic              lsb_first,
    input  logic              hold,
    output logic [6:0]        segments,
    output logic              dp,
    output logic [DIGITS-1:0] digit_en,
    output logic [IDX_W-1:0]  index,
    output logic              valid
);

    localparam int PRE_W = $clog2(SCAN_DIV);

    logic [WIDTH-1:0]  s1_q, s2_q;
    logic [IDX_W-1:0]  enc_idx;
    logic              enc_valid;
    logic [IDX_W-1:0]  index_q;
    logic              valid_q;
    logic [PRE_W-1:0]  pre_q;
    logic              ptr_q;
    logic [6:0]        idx_ext;
    logic [3:0]        tens, units;
    logic [3:0]        bcd_sel;
    logic              blank_sel;
    logic [6:0]        dec_seg;
    logic [6:0]        seg_q;
    logic              dp_q;
    logic [DIGITS-1:0] en_q;

    // Two-flop synchroniser for the asynchronous request bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= data;
            s2_q <= s1_q;
        end
    end

    // Priority encoder: the scan order is chosen so that the winning bit
    // is the last one to assign enc_idx.
    always_comb begin
        enc_idx = '0;
        if (lsb_first) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (s2_q[i]) enc_idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2_q[i]) enc_idx = IDX_W'(i);
            end
        end
    end

    assign enc_valid = |s2_q;

    // Result register; hold keeps the last value loaded before it rose.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q <= '0;
            valid_q <= 1'b0;
        end else if (!hold) begin
            index_q <= enc_idx;
            valid_q <= enc_valid;
        end
    end

    // Decimal split of the registered index (index never exceeds 63).
    assign idx_ext = 7'(index_q);
    assign tens    = 4'(idx_ext / 7'd10);
    assign units   = 4'(idx_ext % 7'd10);

    // Scan prescaler and digit pointer, independent of hold/valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            ptr_q <= 1'b0;
        end else if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_q <= '0;
            if (ptr_q == 1'(DIGITS - 1)) ptr_q <= 1'b0;
            else                         ptr_q <= ptr_q + 1'b1;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // Units digit shows its value; tens digit suppresses a leading zero;
    // with no data every digit is dark.
    always_comb begin
        bcd_sel   = (ptr_q == 1'b0) ? units : tens;
        blank_sel = !valid_q || ((ptr_q != 1'b0) && (tens == 4'd0));
    end

    seg7_decoder u_seg7 (
        .bcd   (bcd_sel),
        .blank (blank_sel),
        .seg   (dec_seg)
    );

    // Output registers: segments, dp and digit select change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b0;
            en_q  <= DIGITS'(1);
        end else begin
            seg_q <= dec_seg;
            dp_q  <= !valid_q && (ptr_q == 1'b0);
            en_q  <= DIGITS'(1) << ptr_q;
        end
    end

    assign segments = seg_q;
    assign dp       = dp_q;
    assign digit_en = en_q;
    assign index    = index_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_priority_encoder_scan_display.sv
// tb_priority_encoder_scan_display
//   Directed bench for priority_encoder_scan_display with WIDTH=16,
//   DIGITS=2, SCAN_DIV=4. A cycle model derives the expected outputs from
//   the input history; literal expectations pin key points of that model.
module tb_priority_encoder_scan_display;

    localparam int WIDTH    = 16;
    localparam int DIGITS   = 2;
    localparam int SCAN_DIV = 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [15:0] data      = 16'h0;
    logic        lsb_first = 1'b0;
    logic        hold      = 1'b0;
    logic [6:0]  segments;
    logic        dp;
    logic [1:0]  digit_en;
    logic [3:0]  index;
    logic        valid;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    priority_encoder_scan_display #(
        .WIDTH    (WIDTH),
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .lsb_first (lsb_first),
        .hold      (hold),
        .segments  (segments),
        .dp        (dp),
        .digit_en  (digit_en),
        .index     (index),
        .valid     (valid)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0]  seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [15:0] data_hist[$];
    int          cyc     = 0;
    int          m_idx   = 0;
    bit          m_valid = 1'b0;
    logic [6:0]  m_seg   = 7'h00;
    bit          m_dp    = 1'b0;
    logic [1:0]  m_en    = 2'b01;

    // Priority index by arithmetic: MSB position from ceil-log2,
    // LSB position from isolating the lowest set bit.
    function automatic int prio(input logic [15:0] d, input logic lsb);
        int v;
        v = int'(d);
        if (lsb) return $clog2(v & -v);
        return $clog2(v + 1) - 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_hist.delete();
            cyc     = 0;
            m_idx   = 0;
            m_valid = 1'b0;
            m_seg   = 7'h00;
            m_dp    = 1'b0;
            m_en    = 2'b01;
        end else begin
            int          ptr;
            logic [15:0] seen;
            ptr  = (cyc / SCAN_DIV) % DIGITS;
            m_en = 2'(1 << ptr);
            // Display reflects the index as it stood before this edge.
            if (!m_valid) begin
                m_seg = 7'h00;
                m_dp  = (ptr == 0);
            end else if (ptr == 0) begin
                m_seg = seg_tab[m_idx % 10];
                m_dp  = 1'b0;
            end else begin
                m_seg = ((m_idx / 10) == 0) ? 7'h00 : seg_tab[m_idx / 10];
                m_dp  = 1'b0;
            end
            // The encoder sees data applied two edges earlier.
            seen = (cyc >= 2) ? data_hist[cyc - 2] : 16'h0;
            data_hist.push_back(data);
            if (!hold) begin
                m_valid = (seen != 16'h0);
                m_idx   = m_valid ? prio(seen, lsb_first) : 0;
            end
            cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("cyc_segments", 16'(segments), 16'(m_seg));
        chk("cyc_dp",       16'(dp),       16'(m_dp));
        chk("cyc_digit_en", 16'(digit_en), 16'(m_en));
        chk("cyc_valid",    16'(valid),    16'(m_valid));
        if (m_valid) chk("cyc_index", 16'(index), 16'(m_idx));
    end

    // ---------------- driver tasks ----------------
    task automatic apply(input logic [15:0] d, input logic l, input logic h);
        @(negedge clk);
        data      = d;
        lsb_first = l;
        hold      = h;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits (bounded) until the given digit is enabled, then checks it.
    task automatic check_digit(input string name, input logic [1:0] en,
                               input logic [6:0] seg_e, input logic dp_e);
        bit found;
        found = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3 * SCAN_DIV * DIGITS; i++) begin
            @(negedge clk);
            if (digit_en == en) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s: digit_en %b never seen, last %b", name, en, digit_en);
        end else begin
            chk({name, "_seg"}, 16'(segments), 16'(seg_e));
            chk({name, "_dp"},  16'(dp),       16'(dp_e));
        end
    endtask

    task automatic check_reset_state(input string name);
        chk({name, "_segments"}, 16'(segments), 16'h00);
        chk({name, "_dp"},       16'(dp),       16'h0);
        chk({name, "_digit_en"}, 16'(digit_en), 16'h1);
        chk({name, "_index"},    16'(index),    16'h0);
        chk({name, "_valid"},    16'(valid),    16'h0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // MSB priority: 0x0A30 -> bit 11
        apply(16'h0A30, 1'b0, 1'b0);
        tick(3);
        chk("prio_msb_index", 16'(index), 16'd11);
        chk("prio_msb_valid", 16'(valid), 16'd1);
        check_digit("msb_units", 2'b01, 7'h06, 1'b0);
        check_digit("msb_tens",  2'b10, 7'h06, 1'b0);

        // LSB priority on the same data -> bit 4, one cycle later
        apply(16'h0A30, 1'b1, 1'b0);
        tick(1);
        chk("prio_lsb_index", 16'(index), 16'd4);
        check_digit("lsb_units", 2'b01, 7'h66, 1'b0);
        check_digit("lsb_tens",  2'b10, 7'h00, 1'b0);

        // No data
        apply(16'h0000, 1'b0, 1'b0);
        tick(3);
        chk("nodata_valid", 16'(valid), 16'd0);
        check_digit("nodata_units", 2'b01, 7'h00, 1'b1);
        check_digit("nodata_tens",  2'b10, 7'h00, 1'b0);

        // Top bit -> 15
        apply(16'h8000, 1'b0, 1'b0);
        tick(3);
        chk("top_index", 16'(index), 16'd15);
        check_digit("top_units", 2'b01, 7'h6D, 1'b0);
        check_digit("top_tens",  2'b10, 7'h06, 1'b0);

        // Hold freezes, release resumes next cycle
        apply(16'h0004, 1'b0, 1'b0);
        tick(3);
        chk("hold_pre_index", 16'(index), 16'd2);
        apply(16'h0100, 1'b0, 1'b1);
        tick(5);
        chk("hold_frozen_index", 16'(index), 16'd2);
        apply(16'h0100, 1'b0, 1'b0);
        tick(1);
        chk("hold_release_index", 16'(index), 16'd8);

        // Single-bit sweep, both priority directions
        for (int l = 0; l < 2; l++) begin
            for (int b = 0; b < WIDTH; b++) begin
                exp_q.push_back(4'(b));
                apply(16'(1) << b, 1'(l), 1'b0);
                tick(3);
                chk("sweep_index", 16'(index), 16'(exp_q.pop_front()));
            end
        end

        // Asynchronous reset in the middle of a scan
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        apply(16'h0A30, 1'b0, 1'b0);
        tick(3);
        chk("post_reset_index", 16'(index), 16'd11);
        check_digit("post_reset_units", 2'b01, 7'h06, 1'b0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
